// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared constants for the RegisterBank write path: bank geometry, requester
// count and the fixed requester index assignment, plus the round-robin index
// type and its modulo-4 successor helper.
// -----------------------------------------------------------------------------
package regbank_pkg;

   localparam int NUM_REGS = 8;
   localparam int REG_W    = 16;
   localparam int SEL_W    = 3;
   localparam int NREQ     = 4;
   localparam int PTR_W    = 2;

   // Requester slots on the arbiter inputs.
   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_SEQ = 2;
   localparam int REQ_DBG = 3;

   typedef logic [PTR_W-1:0] ReqIdxT;

   // Next requester in round-robin order; the 2-bit index wraps 3 -> 0 naturally.
   function automatic ReqIdxT nextIdx(input ReqIdxT Idx);
      return Idx + ReqIdxT'(1);
   endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational first-valid finder. Scans Start, Start+1, ... (mod NREQ) and
// reports the first requester that is valid and not excluded.
//   Valid   in  NREQ   candidate requests
//   Start   in  PTR_W  highest-priority index for this scan
//   Exclude in  NREQ   requesters to skip
//   Found   out 1      a candidate was found
//   Index   out PTR_W  index of that candidate (Start when none found)
// -----------------------------------------------------------------------------
module rr_pick
   import regbank_pkg::*;
(
   input  logic [NREQ-1:0]  Valid,
   input  logic [PTR_W-1:0] Start,
   input  logic [NREQ-1:0]  Exclude,
   output logic             Found,
   output logic [PTR_W-1:0] Index
);

   always_comb begin
      logic [PTR_W-1:0] Idx;
      // NOTE: every output gets a default before the loop so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      Found = 1'b0;
      Index = Start;
      Idx   = Start;
      // Scan from the farthest offset down to Start so the nearest hit is the
      // last assignment and therefore wins.
      for (int Off = NREQ - 1; Off >= 0; Off--) begin
         Idx = Start + PTR_W'(Off);
         if (Valid[Idx] && !Exclude[Idx]) begin
            Found = 1'b1;
            Index = Idx;
         end
      end
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_write_arbiter
// Shares the RegisterBank's two write ports (Rx, Ry) between four requesters
// (ALU, memory load, micro-sequencer, debug/host) with a round-robin arbiter.
// Up to two writes to different registers are granted per cycle and registered
// onto the bank write ports one cycle after acceptance.
//   ClockInput         in   system clock (rising edge)
//   ResetN             in   asynchronous active-low reset
//   ReqValid/Sel/Data  in   per-requester write request, packed k-major
//   ReqReady           out  combinational grant (transfer on Valid & Ready)
//   Hold               in   control-unit freeze, blocks all grants
//   RxSel/WriteData_Rx/WriteRx, RySel/WriteData_Ry/WriteRy  out  bank write ports
//   PendingMask        out  registers being written by the current port values
// -----------------------------------------------------------------------------
module regbank_write_arbiter #(
   parameter int NREQ = regbank_pkg::NREQ,
   parameter int DW   = regbank_pkg::REG_W,
   parameter int SW   = regbank_pkg::SEL_W
) (
   input  logic             ClockInput,
   input  logic             ResetN,
   input  logic [NREQ-1:0]    ReqValid,
   input  logic [NREQ*SW-1:0] ReqSel,
   input  logic [NREQ*DW-1:0] ReqData,
   output logic [NREQ-1:0]    ReqReady,
   input  logic             Hold,
   output logic [SW-1:0]    RxSel,
   output logic [DW-1:0]    WriteData_Rx,
   output logic             WriteRx,
   output logic [SW-1:0]    RySel,
   output logic [DW-1:0]    WriteData_Ry,
   output logic             WriteRy,
   output logic [7:0]       PendingMask
);

   import regbank_pkg::*;

   ReqIdxT          RrPtr;
   logic [SW-1:0]   SelOf  [NREQ];
   logic [DW-1:0]   DataOf [NREQ];
   logic [NREQ-1:0] ActiveValid;
   logic [NREQ-1:0] SameSel;
   logic            RxFound, RyFound;
   ReqIdxT          RxIdx, RyIdx;

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign SelOf[k]  = ReqSel[k*SW +: SW];
      assign DataOf[k] = ReqData[k*DW +: DW];
      // Includes the Rx winner itself, so the Ry scan can never pick it again.
      assign SameSel[k] = (SelOf[k] == SelOf[RxIdx]);
   end

   assign ActiveValid = ReqValid & {NREQ{~Hold}};

   rr_pick u_rx_pick (
      .Valid   (ActiveValid),
      .Start   (RrPtr),
      .Exclude ({NREQ{1'b0}}),
      .Found   (RxFound),
      .Index   (RxIdx)
   );

   rr_pick u_ry_pick (
      .Valid   (ActiveValid & {NREQ{RxFound}}),
      .Start   (nextIdx(RxIdx)),
      .Exclude (SameSel),
      .Found   (RyFound),
      .Index   (RyIdx)
   );

   // Grants are forced low while reset is asserted so no requester sees a
   // transfer that the cleared output registers would then drop.
   always_comb begin
      ReqReady = '0;
      for (int k = 0; k < NREQ; k++) begin
         ReqReady[k] = ResetN &&
                       ((RxFound && RxIdx == PTR_W'(k)) ||
                        (RyFound && RyIdx == PTR_W'(k)));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge ClockInput or negedge ResetN) begin
      if (!ResetN) begin
         RrPtr        <= '0;
         WriteRx      <= 1'b0;
         WriteRy      <= 1'b0;
         RxSel        <= '0;
         RySel        <= '0;
         WriteData_Rx <= '0;
         WriteData_Ry <= '0;
      end else begin
         WriteRx <= RxFound;
         WriteRy <= RyFound;
         if (RxFound) begin
            RxSel        <= SelOf[RxIdx];
            WriteData_Rx <= DataOf[RxIdx];
            // Priority restarts just after the last requester served.
            RrPtr        <= RyFound ? nextIdx(RyIdx) : nextIdx(RxIdx);
         end
         if (RyFound) begin
            RySel        <= SelOf[RyIdx];
            WriteData_Ry <= DataOf[RyIdx];
         end
      end
   end

   // Rx and Ry never carry the same Sel, so at most one term per bit is set.
   always_comb begin
      PendingMask = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         PendingMask[i] = (WriteRx && RxSel == SW'(i)) ||
                          (WriteRy && RySel == SW'(i));
      end
   end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbank_write_arbiter
// Scoreboard bench: a priority-list reference model predicts the grants and
// the registered port contents; the driver pushes each cycle's prediction and
// an independent monitor compares the bank ports after every rising edge.
// -----------------------------------------------------------------------------
module tb_regbank_write_arbiter;

   logic        ClockInput = 1'b0;
   logic        ResetN;
   logic [3:0]  ReqValid;
   logic [11:0] ReqSel;
   logic [63:0] ReqData;
   logic [3:0]  ReqReady;
   logic        Hold;
   logic [2:0]  RxSel, RySel;
   logic [15:0] WriteData_Rx, WriteData_Ry;
   logic        WriteRx, WriteRy;
   logic [7:0]  PendingMask;

   regbank_write_arbiter dut (
      .ClockInput   (ClockInput),
      .ResetN       (ResetN),
      .ReqValid     (ReqValid),
      .ReqSel       (ReqSel),
      .ReqData      (ReqData),
      .ReqReady     (ReqReady),
      .Hold         (Hold),
      .RxSel        (RxSel),
      .WriteData_Rx (WriteData_Rx),
      .WriteRx      (WriteRx),
      .RySel        (RySel),
      .WriteData_Ry (WriteData_Ry),
      .WriteRy      (WriteRy),
      .PendingMask  (PendingMask)
   );

   always #5 ClockInput = ~ClockInput;

   // Requester-side view of the inputs.
   logic [3:0]  tbValid;
   logic [2:0]  tbSel  [4];
   logic [15:0] tbData [4];
   logic        tbHold;

   always_comb begin
      ReqSel  = '0;
      ReqData = '0;
      for (int k = 0; k < 4; k++) begin
         ReqSel[k*3 +: 3]   = tbSel[k];
         ReqData[k*16 +: 16] = tbData[k];
      end
      ReqValid = tbValid;
      Hold     = tbHold;
   end

   typedef struct {
      bit          wrx;
      logic [2:0]  rxSel;
      logic [15:0] rxData;
      bit          wry;
      logic [2:0]  rySel;
      logic [15:0] ryData;
   } ExpT;

   ExpT scb[$];
   ExpT expState;
   int  mPtr;
   int  nChecks = 0;
   int  nFails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: list valid requesters in priority order starting at mPtr;
   // Rx is the head, Ry is the next entry with a different target register.
   function automatic void modelPick(output int rx, output int ry);
      int order[$];
      rx = -1;
      ry = -1;
      if (tbHold) return;
      for (int off = 0; off < 4; off++)
         if (tbValid[(mPtr + off) % 4]) order.push_back((mPtr + off) % 4);
      if (order.size() == 0) return;
      rx = order[0];
      for (int j = 1; j < order.size(); j++)
         if (tbSel[order[j]] != tbSel[rx]) begin
            ry = order[j];
            break;
         end
   endfunction

   // Called just after a falling edge with inputs settled; returns at the next
   // falling edge. Predicts and checks the grant, queues the port prediction.
   task automatic stepCycle(output logic [3:0] grant, output logic [3:0] dutReady);
      int rx, ry;
      #3;
      modelPick(rx, ry);
      grant = '0;
      if (rx >= 0) grant[rx] = 1'b1;
      if (ry >= 0) grant[ry] = 1'b1;
      dutReady = ReqReady;
      check("ReqReady", ReqReady, grant);
      expState.wrx = (rx >= 0);
      expState.wry = (ry >= 0);
      if (rx >= 0) begin
         expState.rxSel  = tbSel[rx];
         expState.rxData = tbData[rx];
         mPtr = (((ry >= 0) ? ry : rx) + 1) % 4;
      end
      if (ry >= 0) begin
         expState.rySel  = tbSel[ry];
         expState.ryData = tbData[ry];
      end
      scb.push_back(expState);
      @(negedge ClockInput);
   endtask

   // Monitor: compares the registered bank ports after each rising edge.
   initial begin
      ExpT e;
      logic [7:0] expMask;
      forever begin
         @(posedge ClockInput);
         #1;
         if (scb.size() > 0) begin
            e = scb.pop_front();
            expMask = '0;
            if (e.wrx) expMask[e.rxSel] = 1'b1;
            if (e.wry) expMask[e.rySel] = 1'b1;
            check("WriteRx", WriteRx, e.wrx);
            check("WriteRy", WriteRy, e.wry);
            check("RxSel", RxSel, e.rxSel);
            check("WriteData_Rx", WriteData_Rx, e.rxData);
            check("RySel", RySel, e.rySel);
            check("WriteData_Ry", WriteData_Ry, e.ryData);
            check("PendingMask", PendingMask, expMask);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic resetModel();
      scb.delete();
      expState = '{wrx: 0, rxSel: '0, rxData: '0, wry: 0, rySel: '0, ryData: '0};
      mPtr = 0;
   endtask

   initial begin
      logic [3:0] grant, rdy;
      int served[4];

      // Reset with every requester asking.
      resetModel();
      ResetN = 1'b0;
      tbHold = 1'b0;
      tbValid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         tbSel[k]  = 3'(k);
         tbData[k] = 16'(k + 1);
      end
      #2;
      check("reset ReqReady", ReqReady, 4'b0000);
      check("reset WriteRx", WriteRx, 1'b0);
      check("reset WriteRy", WriteRy, 1'b0);
      check("reset PendingMask", PendingMask, 8'h00);
      repeat (2) @(negedge ClockInput);
      check("reset ReqReady held", ReqReady, 4'b0000);
      tbValid = 4'h0;
      ResetN  = 1'b1;

      // Dual grant from pointer 0.
      tbSel[0] = 3'd2; tbData[0] = 16'h00AA;
      tbSel[1] = 3'd5; tbData[1] = 16'h0BBB;
      tbValid  = 4'b0011;
      #1 check("dual ReqReady", ReqReady, 4'b0011);
      stepCycle(grant, rdy);
      tbValid = tbValid & ~grant;

      // Single request from 3 moves the pointer back to 0.
      tbSel[3] = 3'd7; tbData[3] = 16'h7777;
      tbValid  = 4'b1000;
      stepCycle(grant, rdy);
      tbValid = tbValid & ~grant;

      // Same-register conflict: only req0 this cycle, req1 next.
      tbSel[0] = 3'd3; tbData[0] = 16'h0303;
      tbSel[1] = 3'd3; tbData[1] = 16'h1313;
      tbValid  = 4'b0011;
      #1 check("conflict ReqReady", ReqReady, 4'b0001);
      stepCycle(grant, rdy);
      tbValid = tbValid & ~grant;
      #1 check("conflict followup ReqReady", ReqReady, 4'b0010);
      stepCycle(grant, rdy);
      tbValid = tbValid & ~grant;

      // Fairness: all four valid on distinct registers, new data each grant.
      for (int k = 0; k < 4; k++) begin
         tbSel[k] = 3'(2 * k);
         served[k] = 0;
      end
      tbValid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         stepCycle(grant, rdy);
         for (int k = 0; k < 4; k++) begin
            if (rdy[k]) served[k]++;
            if (grant[k]) tbData[k] = 16'($urandom);
         end
      end
      for (int k = 0; k < 4; k++) check($sformatf("fair served[%0d]", k), served[k], 4);

      // Hold for three cycles with everyone valid, then release.
      tbHold = 1'b1;
      #1 check("hold ReqReady", ReqReady, 4'b0000);
      repeat (3) stepCycle(grant, rdy);
      tbHold = 1'b0;
      repeat (2) begin
         stepCycle(grant, rdy);
         for (int k = 0; k < 4; k++) if (grant[k]) tbData[k] = 16'($urandom);
      end

      // Random traffic; requesters hold their request until accepted.
      tbValid = 4'h0;
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (!tbValid[k] && $urandom_range(0, 2) != 0) begin
               tbValid[k] = 1'b1;
               tbSel[k]   = 3'($urandom_range(0, 7));
               tbData[k]  = 16'($urandom);
            end
         end
         tbHold = ($urandom_range(0, 9) == 0);
         stepCycle(grant, rdy);
         tbValid = tbValid & ~grant;
      end
      tbHold = 1'b0;

      // Asynchronous reset while a write is on the port.
      tbValid  = 4'b0100;
      tbSel[2] = 3'd6; tbData[2] = 16'h1234;
      stepCycle(grant, rdy);
      tbValid = 4'hF;
      #1 ResetN = 1'b0;
      #1;
      check("async WriteRx", WriteRx, 1'b0);
      check("async PendingMask", PendingMask, 8'h00);
      check("async ReqReady", ReqReady, 4'b0000);
      resetModel();
      @(negedge ClockInput);
      ResetN = 1'b1;
      for (int k = 0; k < 4; k++) tbSel[k] = 3'(k + 4);
      #1 check("post-reset ReqReady", ReqReady, 4'b0011);
      stepCycle(grant, rdy);
      tbValid = 4'h0;
      repeat (2) stepCycle(grant, rdy);

      @(posedge ClockInput);
      #2 check("scoreboard drained", scb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Shares the RegisterBank's two write ports (Rx, Ry) between four write requesters: ALU result, memory load, micro-sequencer immediate, and debug/host. The block runs a round-robin arbiter with valid/ready handshakes and grants up to two non-conflicting writes per cycle. It registers the winning select/data/enable onto the bank's write ports, one cycle after acceptance. It also exports a pending-write mask so the control unit can stall dependent reads.

## Interface
Parameters:
- NREQ, 4: number of requesters (fixed at 4; pointer is 2 bits)
- DW, 16: register data width
- SW, 3: register select width (8 registers)

Ports:
- ClockInput  in  1  system clock, all state on rising edge
- ResetN  in  1  asynchronous, active-low reset
- ReqValid  in  NREQ  per-requester write request
- ReqSel  in  NREQ*SW  target register, requester k at [k*SW +: SW]
- ReqData  in  NREQ*DW  write data, requester k at [k*DW +: DW]
- ReqReady  out  NREQ  combinational grant; transfer when ReqValid[k] & ReqReady[k]
- Hold  in  1  control-unit freeze; no grants while high
- RxSel  out  SW  to bank RxSel (write side)
- WriteData_Rx  out  DW  to bank
- WriteRx  out  1  to bank
- RySel  out  SW  to bank RySel (write side)
- WriteData_Ry  out  DW  to bank
- WriteRy  out  1  to bank
- PendingMask  out  8  bit i high while a write to register i is being driven this cycle

## Operation
- Round-robin pointer RrPtr (2 bits) names the highest-priority requester this cycle.
- Rx pick: the first k scanning RrPtr, RrPtr+1, … (mod 4) with ReqValid[k]=1. This is the Rx winner.
- Ry pick: continue the scan after the Rx winner. Take the first valid k whose ReqSel differs from the Rx winner's ReqSel. This is the Ry winner.
- Requesters targeting the same register as the Rx winner are skipped this cycle. Their ReqReady stays 0.
- ReqReady[k]=1 only for the Rx and Ry winners. All ReqReady are 0 when Hold=1 or no request is valid.
- ReqReady depends combinationally on all ReqValid/ReqSel. Requesters must not derive ReqValid from ReqReady. A requester holds ReqValid/Sel/Data stable until it is accepted.
- Pointer update on each edge with at least one grant: RrPtr ← (index of last winner + 1) mod 4. The last winner is Ry if granted, else Rx. RrPtr is unchanged when there is no grant or Hold=1.
- Output registers on each edge:
  - RxSel/WriteData_Rx/WriteRx ← Rx winner's sel/data/1, or WriteRx ← 0 if no Rx winner. Same for Ry.
  - Sel/data hold their last value when the enable is 0.
- PendingMask[i] = (WriteRx & RxSel==i) | (WriteRy & RySel==i). It is decoded from the registered outputs and is never 2 bits for the same register.
- Two grants never carry the same Sel, so the bank's Rx-over-Ry precedence is never exercised.

## Timing
- Reset (async assert, sync-safe release): RrPtr=0, WriteRx=WriteRy=0, RxSel=RySel=0, WriteData_Rx=WriteData_Ry=0, PendingMask=0, ReqReady=0 while ResetN=0.
- Latency: request accepted at edge N → bank write enables are high during cycle N..N+1 → register updated at edge N+1. Total two edges from acceptance to visible read.
- Throughput: up to 2 writes per cycle. Sustained per-requester service is guaranteed within 4 grant cycles (no starvation).
- Hold rising: grants stop in the same cycle. At the next edge WriteRx/WriteRy go to 0. A write already registered still completes.
- Reset mid-operation: an in-flight registered write is dropped (enables cleared asynchronously). Requesters must re-present it.

## Structure
- Shared package regbank_pkg: NUM_REGS=8, REG_W=16, SEL_W=3, NREQ=4, requester index constants (REQ_ALU=0, REQ_MEM=1, REQ_SEQ=2, REQ_DBG=3).
- Sub-module rr_pick: combinational first-valid finder with start pointer and exclusion mask. It returns a found flag and an index. It is instantiated twice: Rx pick, and Ry pick with start=Rx+1 and same-Sel requesters masked.

## Test plan
- Reset: ResetN low with all ReqValid=1. Check ReqReady=0, WriteRx=WriteRy=0, PendingMask=0. After release, RrPtr=0.
- Dual grant: req0 (Sel=2, 0x00AA) and req1 (Sel=5, 0x0BBB) valid at RrPtr=0. Expect ReqReady=0011. Next cycle RxSel=2/0x00AA, RySel=5/0x0BBB, PendingMask=0x24. Bank R2=0x00AA, R5=0x0BBB after the following edge. RrPtr→2.
- Conflict: req0 and req1 both valid with Sel=3, RrPtr=0. Expect ReqReady=0001, only WriteRx next cycle. Then req1 is granted on Rx next cycle with RrPtr=1.
- Fairness: all 4 valid continuously with distinct Sels. Grants are {0,1},{2,3},{0,1}… and each requester is served every 2 cycles.
- Hold: all valid, Hold=1 for 3 cycles. Expect ReqReady=0, WriteRx/WriteRy=0 after one edge, RrPtr frozen. Grants resume from the same RrPtr on release.
- Async reset mid-write: assert ResetN low between edges while WriteRx=1. WriteRx clears immediately and the target register is unchanged.
